// File: rtl/mb_stream_packer_if.sv
// Stream-side bundle of mb_stream_packer: the macroblock-record FIFO read port
// and the 512-bit AXI-Stream style output.
interface mb_stream_packer_if;
  logic          fifo_empty;
  logic          fifo_rd;
  logic [1023:0] fifo_dout;
  logic          m_tvalid;
  logic          m_tready;
  logic [511:0]  m_tdata;
  logic          m_tlast;
  logic [3:0]    m_tuser;

  modport master (
    input  fifo_empty, fifo_dout, m_tready,
    output fifo_rd, m_tvalid, m_tdata, m_tlast, m_tuser
  );

  modport slave (
    output fifo_empty, fifo_dout, m_tready,
    input  fifo_rd, m_tvalid, m_tdata, m_tlast, m_tuser
  );
endinterface

// File: rtl/mb_stream_packer.sv
// Unpacks 7-word (1024-bit) macroblock records from a FIFO into 14 512-bit beats.
// Optional stall counter output is enabled by defining MB_STREAM_STALL_CNT_EN.
module mb_stream_packer (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [19:0]        mb_total,
  mb_stream_packer_if.master bus,
  output logic               busy,
  output logic               done
`ifdef MB_STREAM_STALL_CNT_EN
  ,
  output logic [31:0]        stall_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RDEN    = 3'd1,
    LOAD    = 3'd2,
    SEND_LO = 3'd3,
    SEND_HI = 3'd4,
    DONE    = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [1023:0] hold_q;
  logic [2:0]    word_idx_q;
  logic [19:0]   mb_cnt_q;
  logic [19:0]   mb_total_q;
  logic          done_q;

  logic          fifo_rd_s;
  logic          tvalid_s;
  logic [511:0]  tdata_s;
  logic          tlast_s;
  logic [3:0]    tuser_s;
  logic          hs_s;
  logic          mb_end_s;
  logic          final_beat_s;

  assign hs_s         = tvalid_s & bus.m_tready;
  assign mb_end_s     = (state_q == SEND_HI) && (word_idx_q == 3'd6);
  assign final_beat_s = mb_end_s && (mb_cnt_q == (mb_total_q - 20'd1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = (mb_total == 20'd0) ? DONE : RDEN;
        end else begin
          state_d = IDLE;
        end
      end
      RDEN: begin
        if (!bus.fifo_empty) begin
          state_d = LOAD;
        end else begin
          state_d = RDEN;
        end
      end
      LOAD:    state_d = SEND_LO;
      SEND_LO: begin
        if (hs_s) begin
          state_d = SEND_HI;
        end else begin
          state_d = SEND_LO;
        end
      end
      SEND_HI: begin
        if (hs_s) begin
          state_d = final_beat_s ? DONE : RDEN;
        end else begin
          state_d = SEND_HI;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode; beat fields are zero whenever no beat is presented
  always_comb begin
    fifo_rd_s = 1'b0;
    tvalid_s  = 1'b0;
    tdata_s   = 512'd0;
    tlast_s   = 1'b0;
    tuser_s   = 4'd0;
    case (state_q)
      RDEN: begin
        fifo_rd_s = ~bus.fifo_empty;
      end
      SEND_LO: begin
        tvalid_s = 1'b1;
        tdata_s  = hold_q[511:0];
        tuser_s  = {word_idx_q, 1'b0};
      end
      SEND_HI: begin
        tvalid_s = 1'b1;
        tdata_s  = hold_q[1023:512];
        tuser_s  = {word_idx_q, 1'b1};
        tlast_s  = (word_idx_q == 3'd6);
      end
      default: begin
        fifo_rd_s = 1'b0;
      end
    endcase
  end

  assign bus.fifo_rd  = fifo_rd_s;
  assign bus.m_tvalid = tvalid_s;
  assign bus.m_tdata  = tdata_s;
  assign bus.m_tlast  = tlast_s;
  assign bus.m_tuser  = tuser_s;
  assign busy         = (state_q != IDLE);
  assign done         = done_q;

  // Frame datapath: word capture, beat/macroblock counters, done pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q     <= 1024'd0;
      word_idx_q <= 3'd0;
      mb_cnt_q   <= 20'd0;
      mb_total_q <= 20'd0;
      done_q     <= 1'b0;
    end else begin
      if ((state_q == IDLE) && start) begin
        mb_total_q <= mb_total;
        word_idx_q <= 3'd0;
        mb_cnt_q   <= 20'd0;
      end
      if (state_q == LOAD) begin
        hold_q <= bus.fifo_dout;
      end
      if ((state_q == SEND_HI) && hs_s) begin
        word_idx_q <= (word_idx_q == 3'd6) ? 3'd0 : (word_idx_q + 3'd1);
        if (mb_end_s) begin
          mb_cnt_q <= mb_cnt_q + 20'd1;
        end
      end
      done_q <= (state_q == DONE);
    end
  end

`ifdef MB_STREAM_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Back-pressure cycle counter, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= 32'd0;
    end else if ((state_q == IDLE) && start) begin
      stall_cnt_q <= 32'd0;
    end else if (tvalid_s && !bus.m_tready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_mb_stream_packer.sv
// Directed, table-driven bench for mb_stream_packer with a non-show-ahead FIFO model.
module tb_mb_stream_packer;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [19:0] mb_total;
  logic        busy;
  logic        done;
`ifdef MB_STREAM_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  mb_stream_packer_if bus ();

  mb_stream_packer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .mb_total (mb_total),
    .bus      (bus),
    .busy     (busy),
    .done     (done)
`ifdef MB_STREAM_STALL_CNT_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [19:0] mbt;
    int          ready_mode;
    bit          gap;
    bit          restart;
    int          exp_beats;
    int          exp_lasts;
    int          exp_rds;
  } row_t;

  row_t rows[5];

  logic [1023:0] q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  int            ready_mode, gap_rem, beat_in_mb, gb;
  bit            gap_en, gap_done, prev_stall, rd_pend;
  logic [511:0]  prev_data;
  logic [15:0]   seed;
  int            n_beats, n_lasts, n_rds, n_dones, n_stalls, n_valid;
  logic          smp_done, smp_busy;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] beat_val(input logic [15:0] sd, input int b);
    logic [31:0] w;
    w = {sd, 16'(b)};
    return {16{w}};
  endfunction

  task automatic reset_monitor();
    beat_in_mb = 0; gb = 0; gap_rem = 0; gap_done = 0; prev_stall = 0; rd_pend = 0;
    n_beats = 0; n_lasts = 0; n_rds = 0; n_dones = 0; n_stalls = 0; n_valid = 0;
  endtask

  // One clock: drive inputs and check outputs mid-cycle, then serve the FIFO read after the edge
  task automatic tick();
    logic rdy;
    bit   forced;
    @(negedge clk);
    cyc++;
    case (ready_mode)
      1:       rdy = cyc[0];
      2:       rdy = ((cyc % 3) != 2);
      default: rdy = 1'b1;
    endcase
    forced         = (gap_rem > 0);
    bus.m_tready   = rdy;
    bus.fifo_empty = forced || (q.size() == 0);
    #1;
    smp_done = done;
    smp_busy = busy;
    if (forced) begin
      chk("gap_fifo_rd", {511'd0, bus.fifo_rd}, 512'd0);
      chk("gap_tvalid", {511'd0, bus.m_tvalid}, 512'd0);
      gap_rem--;
    end
    if (bus.fifo_rd) begin
      n_rds++;
      rd_pend = 1'b1;
    end
    if (bus.m_tvalid) begin
      n_valid++;
      chk("busy_in_frame", {511'd0, busy}, 512'd1);
      chk("tuser", {508'd0, bus.m_tuser}, 512'(beat_in_mb));
      chk("tlast", {511'd0, bus.m_tlast}, {511'd0, (beat_in_mb == 13)});
      chk("tdata", bus.m_tdata, beat_val(seed, gb));
      if (prev_stall) chk("tdata_stable", bus.m_tdata, prev_data);
      if (rdy) begin
        n_beats++;
        if (bus.m_tlast) n_lasts++;
        if (gap_en && !gap_done && beat_in_mb == 5) begin
          gap_rem  = 5;
          gap_done = 1'b1;
        end
        beat_in_mb = (beat_in_mb == 13) ? 0 : beat_in_mb + 1;
        gb++;
      end else begin
        n_stalls++;
      end
      prev_stall = !rdy;
      prev_data  = bus.m_tdata;
    end else begin
      prev_stall = 1'b0;
    end
    if (done) n_dones++;
    @(posedge clk);
    #1;
    if (rd_pend && q.size() > 0) bus.fifo_dout = q.pop_front();
    rd_pend = 1'b0;
  endtask

  task automatic run_frame(input row_t r, input logic [15:0] sd);
    int budget;
    reset_monitor();
    seed       = sd;
    ready_mode = r.ready_mode;
    gap_en     = r.gap;
    for (int k = 0; k < 7 * int'(r.mbt); k++)
      q.push_back({beat_val(sd, 2 * k + 1), beat_val(sd, 2 * k)});
    mb_total = r.mbt;
    start    = 1'b1;
    tick();
    start    = 1'b0;
    mb_total = 20'd7;
    budget   = 150 * int'(r.mbt) + 50;
    for (int c = 0; c < budget && n_dones == 0; c++) begin
      if (r.restart && c == 6) begin
        start    = 1'b1;
        mb_total = 20'd5;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    start = 1'b0;
    repeat (3) tick();
    chk("done_count", 512'(n_dones), 512'd1);
    chk("beat_count", 512'(n_beats), 512'(r.exp_beats));
    chk("tlast_count", 512'(n_lasts), 512'(r.exp_lasts));
    chk("fifo_rd_count", 512'(n_rds), 512'(r.exp_rds));
    chk("busy_after", {511'd0, busy}, 512'd0);
    chk("fifo_drained", 512'(q.size()), 512'd0);
`ifdef MB_STREAM_STALL_CNT_EN
    chk("stall_cnt", {480'd0, stall_cnt}, 512'(n_stalls));
`endif
    ready_mode = 0;
    gap_en     = 1'b0;
  endtask

  initial begin
    rows[0] = '{mbt: 20'd1, ready_mode: 0, gap: 1'b0, restart: 1'b0, exp_beats: 14, exp_lasts: 1, exp_rds: 7};
    rows[1] = '{mbt: 20'd2, ready_mode: 1, gap: 1'b0, restart: 1'b0, exp_beats: 28, exp_lasts: 2, exp_rds: 14};
    rows[2] = '{mbt: 20'd1, ready_mode: 0, gap: 1'b1, restart: 1'b0, exp_beats: 14, exp_lasts: 1, exp_rds: 7};
    rows[3] = '{mbt: 20'd3, ready_mode: 2, gap: 1'b0, restart: 1'b0, exp_beats: 42, exp_lasts: 3, exp_rds: 21};
    rows[4] = '{mbt: 20'd1, ready_mode: 0, gap: 1'b0, restart: 1'b1, exp_beats: 14, exp_lasts: 1, exp_rds: 7};

    rst_n = 1'b0; start = 1'b0; mb_total = 20'd0;
    bus.m_tready = 1'b0; bus.fifo_empty = 1'b1; bus.fifo_dout = 1024'd0;
    ready_mode = 0; gap_en = 1'b0; seed = 16'd0;
    reset_monitor();
    repeat (2) tick();
    chk("rst_fifo_rd", {511'd0, bus.fifo_rd}, 512'd0);
    chk("rst_tvalid", {511'd0, bus.m_tvalid}, 512'd0);
    chk("rst_tdata", bus.m_tdata, 512'd0);
    chk("rst_tuser", {508'd0, bus.m_tuser}, 512'd0);
    chk("rst_busy", {511'd0, busy}, 512'd0);
    chk("rst_done", {511'd0, done}, 512'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 5; i++) run_frame(rows[i], 16'(i + 1));

    // Empty frame: done two cycles after start, no reads, no beats
    reset_monitor();
    mb_total = 20'd0;
    start    = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("zero_done_c1", {511'd0, smp_done}, 512'd0);
    chk("zero_busy_c1", {511'd0, smp_busy}, 512'd1);
    tick();
    chk("zero_done_c2", {511'd0, smp_done}, 512'd1);
    tick();
    chk("zero_done_c3", {511'd0, smp_done}, 512'd0);
    chk("zero_busy_c3", {511'd0, smp_busy}, 512'd0);
    chk("zero_no_rd", 512'(n_rds), 512'd0);
    chk("zero_no_valid", 512'(n_valid), 512'd0);

    // Asynchronous reset while beat 5 is presented
    reset_monitor();
    seed = 16'h00AA;
    for (int k = 0; k < 14; k++) q.push_back({beat_val(seed, 2 * k + 1), beat_val(seed, 2 * k)});
    mb_total = 20'd2;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 200 && gb < 5; c++) tick();
    @(negedge clk);
    #1;
    chk("pre_rst_tuser", {508'd0, bus.m_tuser}, 512'd5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tvalid", {511'd0, bus.m_tvalid}, 512'd0);
    chk("mid_rst_tdata", bus.m_tdata, 512'd0);
    chk("mid_rst_tlast", {511'd0, bus.m_tlast}, 512'd0);
    chk("mid_rst_tuser", {508'd0, bus.m_tuser}, 512'd0);
    chk("mid_rst_fifo_rd", {511'd0, bus.fifo_rd}, 512'd0);
    chk("mid_rst_busy", {511'd0, busy}, 512'd0);
    chk("mid_rst_done", {511'd0, done}, 512'd0);
    @(posedge clk);
    #1;
    tick();
    rst_n = 1'b1;
    q.delete();
    reset_monitor();
    for (int k = 0; k < 7; k++) q.push_back(1024'd0);
    repeat (4) tick();
    chk("idle_no_rd", 512'(n_rds), 512'd0);
    chk("idle_no_valid", 512'(n_valid), 512'd0);
    q.delete();
    run_frame(rows[0], 16'h00BB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
